// File: rtl/ddr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arb_pkg
//  Description : Shared types and constants for the two-port DDR arbiter.
//                NUM_REQ          - number of requesters sharing the port
//                ADDR_W_DEF       - default DDR user-interface word address width
//                DATA_W_DEF       - default user data width
//                req_id_t         - requester identifier carried by read tags
//                cmd_t            - one requester command (we, addr, wdata)
//                other_req()      - the requester that is not the given one
//  Revision    : 1.0 - initial release
// ============================================================================
package ddr_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W_DEF = 25;
    localparam int DATA_W_DEF = 256;

    typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

    // With two requesters the "other" one is simply the inverted id.
    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr_arb_tag_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_arb_tag_fifo
//  Description : In-order FIFO of requester ids for outstanding DDR reads.
//                Full at DEPTH entries; a pop in the same cycle does not
//                admit a push while full. Pops on empty are ignored.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push/i_push_id - enqueue one id
//                i_pop           - dequeue the head id
//                o_pop_id        - current head id (valid when !o_empty)
//                o_full/o_empty  - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_arb_tag_fifo
    import ddr_arb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  req_id_t i_push_id,
    input  logic    i_pop,
    output req_id_t o_pop_id,
    output logic    o_full,
    output logic    o_empty
);

    localparam int c_ptr_w = $clog2(DEPTH);

    req_id_t            r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full   = (r_count == (c_ptr_w + 1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign w_push   = i_push & ~o_full;
    assign w_pop    = i_pop & ~o_empty;
    assign o_pop_id = r_mem[r_rd_ptr];

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ptr_w + 1)'(1);
                2'b01:   r_count <= r_count - (c_ptr_w + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ddr_port_arbiter
//  Description : Round-robin arbiter sharing one DDR user interface between
//                two requesters. Grants are combinational (zero latency);
//                read ids are queued so returned data is steered back to the
//                issuing requester in order.
//  Ports       : ui_clk, ui_clk_sync_rst      - clock, sync active-high reset
//                req, req_we, req_addr, req_wdata - per-requester command
//                gnt                          - command accepted this cycle
//                rsp_valid, rsp_data          - read response per requester
//                wr_en, wr_addr, wr_data      - write command to controller
//                rd_en, rd_addr               - read command to controller
//                wr_busy, rd_busy             - controller back-pressure
//                rd_data_valid, rd_data       - controller read return
//                wr_cnt, rd_cnt               - accepted-command counters
//                err_orphan                   - sticky: data with no read tag
//  Revision    : 1.0 - initial release
// ============================================================================
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RD_DEPTH = 8
) (
    input  logic                      ui_clk,
    input  logic                      ui_clk_sync_rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic                      rd_en,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      wr_busy,
    input  logic                      rd_busy,
    input  logic                      rd_data_valid,
    input  logic [DATA_W-1:0]         rd_data,
    output logic [31:0]               wr_cnt,
    output logic [31:0]               rd_cnt,
    output logic                      err_orphan
);

    logic [ADDR_W-1:0]  w_addr  [NUM_REQ];
    logic [DATA_W-1:0]  w_wdata [NUM_REQ];
    logic [NUM_REQ-1:0] w_elig;
    logic               w_any_gnt;
    req_id_t            w_gnt_id;
    logic               w_gnt_we;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_pop;
    logic               w_orphan;
    req_id_t            w_pop_id;

    req_id_t            r_last_gnt;
    logic [31:0]        r_wr_cnt;
    logic [31:0]        r_rd_cnt;
    logic               r_err_orphan;

    // Split the flat buses per requester and work out who could be accepted
    // right now. Reset masks eligibility so no command leaks out during it.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_addr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
            assign w_elig[gi]  = ~ui_clk_sync_rst & req[gi] &
                                 (req_we[gi] ? ~wr_busy : (~rd_busy & ~w_fifo_full));
        end
    endgenerate

    // Only eligible requesters compete, so a blocked one never stalls the
    // other. On a tie the requester that did not win last time goes first.
    always_comb begin
        w_any_gnt = 1'b0;
        w_gnt_id  = '0;
        if (w_elig[0] && w_elig[1]) begin
            w_any_gnt = 1'b1;
            w_gnt_id  = other_req(r_last_gnt);
        end else if (w_elig[0]) begin
            w_any_gnt = 1'b1;
            w_gnt_id  = req_id_t'(0);
        end else if (w_elig[1]) begin
            w_any_gnt = 1'b1;
            w_gnt_id  = req_id_t'(1);
        end
    end

    always_comb begin
        gnt = '0;
        if (w_any_gnt) begin
            gnt[w_gnt_id] = 1'b1;
        end
    end

    assign w_gnt_we = req_we[w_gnt_id];
    assign wr_en    = w_any_gnt & w_gnt_we;
    assign rd_en    = w_any_gnt & ~w_gnt_we;
    assign wr_addr  = w_addr[w_gnt_id];
    assign wr_data  = w_wdata[w_gnt_id];
    assign rd_addr  = w_addr[w_gnt_id];

    // Returned data is matched to the oldest outstanding read. Data arriving
    // with nothing outstanding is flagged and otherwise dropped.
    assign w_pop    = ~ui_clk_sync_rst & rd_data_valid & ~w_fifo_empty;
    assign w_orphan = ~ui_clk_sync_rst & rd_data_valid & w_fifo_empty;

    always_comb begin
        rsp_valid = '0;
        if (w_pop) begin
            rsp_valid[w_pop_id] = 1'b1;
        end
    end

    assign rsp_data = rd_data;

    ddr_arb_tag_fifo #(
        .DEPTH     (RD_DEPTH)
    ) u_tag_fifo (
        .clk       (ui_clk),
        .rst       (ui_clk_sync_rst),
        .i_push    (rd_en),
        .i_push_id (w_gnt_id),
        .i_pop     (w_pop),
        .o_pop_id  (w_pop_id),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // last_gnt resets to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge ui_clk) begin
        if (ui_clk_sync_rst) begin
            r_last_gnt   <= req_id_t'(1);
            r_wr_cnt     <= '0;
            r_rd_cnt     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_any_gnt) begin
                r_last_gnt <= w_gnt_id;
            end
            if (wr_en) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (rd_en) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_orphan) begin
                r_err_orphan <= 1'b1;
            end
        end
    end

    assign wr_cnt     = r_wr_cnt;
    assign rd_cnt     = r_rd_cnt;
    assign err_orphan = r_err_orphan;

endmodule
`default_nettype wire

// File: tb/tb_ddr_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ddr_port_arbiter
//  Description : Directed self-checking bench for ddr_port_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr_port_arbiter;

    localparam int ADDR_W   = 25;
    localparam int DATA_W   = 256;
    localparam int RD_DEPTH = 8;

    logic                 ui_clk = 1'b0;
    logic                 ui_clk_sync_rst;
    logic [1:0]           req;
    logic [1:0]           req_we;
    logic [ADDR_W-1:0]    a0, a1;
    logic [DATA_W-1:0]    d0, d1;
    logic [2*ADDR_W-1:0]  req_addr;
    logic [2*DATA_W-1:0]  req_wdata;
    logic [1:0]           gnt;
    logic [1:0]           rsp_valid;
    logic [DATA_W-1:0]    rsp_data;
    logic                 wr_en;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 wr_busy;
    logic                 rd_busy;
    logic                 rd_data_valid;
    logic [DATA_W-1:0]    rd_data;
    logic [31:0]          wr_cnt;
    logic [31:0]          rd_cnt;
    logic                 err_orphan;

    int checks = 0;
    int errors = 0;

    assign req_addr  = {a1, a0};
    assign req_wdata = {d1, d0};

    always #5 ui_clk = ~ui_clk;

    ddr_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .RD_DEPTH      (RD_DEPTH)
    ) dut (
        .ui_clk          (ui_clk),
        .ui_clk_sync_rst (ui_clk_sync_rst),
        .req             (req),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .gnt             (gnt),
        .rsp_valid       (rsp_valid),
        .rsp_data        (rsp_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .wr_busy         (wr_busy),
        .rd_busy         (rd_busy),
        .rd_data_valid   (rd_data_valid),
        .rd_data         (rd_data),
        .wr_cnt          (wr_cnt),
        .rd_cnt          (rd_cnt),
        .err_orphan      (err_orphan)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen a few
    // units later, well before the next edge.
    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    initial begin
        ui_clk_sync_rst = 1'b1;
        req = 2'b00;  req_we = 2'b00;
        a0 = '0;  a1 = '0;  d0 = '0;  d1 = '0;
        wr_busy = 1'b0;  rd_busy = 1'b0;
        rd_data_valid = 1'b0;  rd_data = '0;
        #1;

        // ---- reset: no command leaks out, state cleared ----
        req = 2'b11;  req_we = 2'b11;
        #2;
        chk("rst_gnt", gnt, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        tick();
        chk("rst_wr_cnt", wr_cnt, 0);
        chk("rst_rd_cnt", rd_cnt, 0);
        chk("rst_err_orphan", err_orphan, 0);
        ui_clk_sync_rst = 1'b0;  req = 2'b00;

        // ---- orphan read data right after reset ----
        rd_data_valid = 1'b1;  rd_data = 256'h0BAD;
        #2;
        chk("orphan_rsp_valid", rsp_valid, 0);
        tick();
        rd_data_valid = 1'b0;
        #2;
        chk("orphan_flag", err_orphan, 1);

        // ---- both write, 4 cycles: 01,10,01,10 ----
        a0 = 25'h100;  a1 = 25'h200;
        d0 = 256'hD0D0_0000_1111;  d1 = 256'hD1D1_0000_2222;
        req = 2'b11;  req_we = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #2;
            chk("wr_rot_gnt", gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("wr_rot_wr_en", wr_en, 1);
            chk("wr_rot_rd_en", rd_en, 0);
            chk("wr_rot_addr", wr_addr, (k % 2 == 0) ? 25'h100 : 25'h200);
            chk("wr_rot_data", wr_data, (k % 2 == 0) ? 256'hD0D0_0000_1111 : 256'hD1D1_0000_2222);
            tick();
        end
        req = 2'b00;
        #2;
        chk("wr_rot_idle_gnt", gnt, 0);
        chk("wr_rot_wr_cnt", wr_cnt, 4);
        chk("wr_rot_rd_cnt", rd_cnt, 0);

        // ---- rd_busy: req0 read blocked, req1 write granted ----
        a0 = 25'h10;
        req = 2'b11;  req_we = 2'b10;  rd_busy = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("rdbusy_gnt", gnt, 2'b10);
            chk("rdbusy_wr_en", wr_en, 1);
            chk("rdbusy_rd_en", rd_en, 0);
            tick();
        end
        // last winner was requester 1, so requester 0 takes the tie
        rd_busy = 1'b0;
        #2;
        chk("rd0_gnt", gnt, 2'b01);
        chk("rd0_rd_en", rd_en, 1);
        chk("rd0_wr_en", wr_en, 0);
        chk("rd0_addr", rd_addr, 25'h10);
        tick();
        a1 = 25'h20;
        req = 2'b10;  req_we = 2'b00;
        #2;
        chk("rd1_gnt", gnt, 2'b10);
        chk("rd1_addr", rd_addr, 25'h20);
        tick();
        req = 2'b00;
        #2;
        chk("rd_rd_cnt", rd_cnt, 2);
        chk("rd_wr_cnt", wr_cnt, 6);

        // ---- in-order responses: A to req0, then B to req1 ----
        rd_data_valid = 1'b1;  rd_data = 256'hAAAA_5555;
        #2;
        chk("rsp_a_valid", rsp_valid, 2'b01);
        chk("rsp_a_data", rsp_data, 256'hAAAA_5555);
        tick();
        rd_data = 256'hBBBB_6666;
        #2;
        chk("rsp_b_valid", rsp_valid, 2'b10);
        chk("rsp_b_data", rsp_data, 256'hBBBB_6666);
        tick();
        rd_data_valid = 1'b0;
        #2;
        chk("rsp_idle_valid", rsp_valid, 0);
        chk("rsp_orphan_sticky", err_orphan, 1);

        // ---- fill tag FIFO with 8 reads ----
        a0 = 25'h30;
        req = 2'b01;  req_we = 2'b00;
        for (int k = 0; k < 8; k++) begin
            #2;
            chk("fill_gnt", gnt, 2'b01);
            tick();
        end
        // 9th read blocked, write from requester 1 still granted
        req = 2'b11;  req_we = 2'b10;
        #2;
        chk("full_gnt_wr", gnt, 2'b10);
        chk("full_wr_en", wr_en, 1);
        chk("full_rd_en", rd_en, 0);
        tick();
        req = 2'b01;  req_we = 2'b00;
        #2;
        chk("full_gnt_rd", gnt, 0);
        // pop while full does not admit a push
        rd_data_valid = 1'b1;  rd_data = 256'hC0;
        #1;
        chk("full_pop_gnt", gnt, 0);
        chk("full_pop_rsp", rsp_valid, 2'b01);
        tick();
        // 7 entries: push and pop together, occupancy stays 7
        #2;
        chk("pushpop_gnt", gnt, 2'b01);
        chk("pushpop_rsp", rsp_valid, 2'b01);
        tick();
        rd_data_valid = 1'b0;
        #2;
        chk("refill_gnt", gnt, 2'b01);
        tick();
        #2;
        chk("refull_gnt", gnt, 0);
        chk("fill_rd_cnt", rd_cnt, 12);
        chk("fill_wr_cnt", wr_cnt, 7);

        // ---- reset with 3 reads outstanding ----
        ui_clk_sync_rst = 1'b1;  req = 2'b00;
        tick();
        ui_clk_sync_rst = 1'b0;
        a0 = 25'h50;
        req = 2'b01;  req_we = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("pre_rst_gnt", gnt, 2'b01);
            tick();
        end
        req = 2'b00;
        #2;
        chk("pre_rst_rd_cnt", rd_cnt, 3);
        ui_clk_sync_rst = 1'b1;
        req = 2'b11;  req_we = 2'b11;  rd_data_valid = 1'b1;
        #2;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_rsp", rsp_valid, 0);
        tick();
        ui_clk_sync_rst = 1'b0;  rd_data_valid = 1'b0;  req = 2'b00;
        #2;
        chk("post_rst_wr_cnt", wr_cnt, 0);
        chk("post_rst_rd_cnt", rd_cnt, 0);
        chk("post_rst_orphan", err_orphan, 0);
        req = 2'b11;  req_we = 2'b11;
        #2;
        chk("post_rst_tie_gnt", gnt, 2'b01);
        chk("post_rst_wr_addr", wr_addr, 25'h50);
        tick();
        req = 2'b00;  rd_data_valid = 1'b1;
        #2;
        chk("stale_rsp_valid", rsp_valid, 0);
        tick();
        rd_data_valid = 1'b0;
        #2;
        chk("stale_orphan", err_orphan, 1);
        chk("final_wr_cnt", wr_cnt, 1);
        chk("final_rd_cnt", rd_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ddr_port_arbiter.md
DDR_PORT_ARBITER -- requirements
Module: ddr_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning DDR user-interface word address width.
REQ-002 SHALL have parameter DATA_W, default 256, meaning user data width.
REQ-003 SHALL have parameter RD_DEPTH, default 8, meaning the maximum number of outstanding reads (power of two).
REQ-004 SHALL have port ui_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port ui_clk_sync_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, [1:0]: per-requester command request.
REQ-007 SHALL have port req_we, input, [1:0]: 1 means write, 0 means read.
REQ-008 SHALL have port req_addr, input, 2 x ADDR_W: per-requester address.
REQ-009 SHALL have port req_wdata, input, 2 x DATA_W: per-requester write data.
REQ-010 SHALL have port gnt, output, [1:0]: command accepted this cycle.
REQ-011 SHALL have port rsp_valid, output, [1:0]: read data valid for that requester.
REQ-012 SHALL have port rsp_data, output, DATA_W: read data shared by both requesters.
REQ-013 SHALL have ports wr_en, output, 1; wr_addr, output, ADDR_W; wr_data, output, DATA_W: write command to the DDR controller.
REQ-014 SHALL have ports rd_en, output, 1; rd_addr, output, ADDR_W: read command to the DDR controller.
REQ-015 SHALL have ports wr_busy, rd_busy, rd_data_valid, input, 1 each; and rd_data, input, DATA_W: DDR controller status and read return.
REQ-016 SHALL have outputs wr_cnt and rd_cnt, 32 bits each: accepted-command counters.
REQ-017 SHALL have output err_orphan, 1 bit: sticky flag for read data returned with no read outstanding.

Function
REQ-018 SHALL treat requester i as eligible when req[i]=1 and either (req_we[i]=1 and wr_busy=0) or (req_we[i]=0, rd_busy=0, and the tag FIFO is not full).
REQ-019 SHALL assert at most one gnt bit per cycle, combinationally from the current inputs and registered state.
REQ-020 SHALL grant the sole eligible requester when only one is eligible; an ineligible requester never blocks the other.
REQ-021 SHALL, when both requesters are eligible, grant the requester that is not last_gnt.
REQ-022 SHALL update the last_gnt register only on a cycle with a grant.
REQ-023 SHALL, on a write grant, drive wr_en=1 with wr_addr and wr_data from the granted requester in the same cycle (zero latency).
REQ-024 SHALL, on a read grant, drive rd_en=1 with rd_addr from the granted requester in the same cycle, and push the requester id into the tag FIFO.
REQ-025 SHALL hold wr_en=0 and rd_en=0 in cycles without the corresponding grant.
REQ-026 SHALL, on rd_data_valid=1 with the FIFO non-empty, pop the head id and assert rsp_valid[id]=1 with rsp_data=rd_data in the same cycle; responses return in issue order.
REQ-027 SHALL treat the FIFO as full at RD_DEPTH entries; a pop in the same cycle does not lift the full condition.
REQ-028 SHALL perform push and pop together when both occur in one cycle with the FIFO neither full nor empty, leaving occupancy unchanged.
REQ-029 SHALL, on rd_data_valid=1 with the FIFO empty, set err_orphan, assert no rsp_valid, and leave the FIFO unchanged.
REQ-030 SHALL increment wr_cnt on each write grant and rd_cnt on each read grant, wrapping modulo 2^32.
REQ-031 SHALL require requesters to hold req, req_we, req_addr and req_wdata stable until granted; the block does not check this.

Reset
REQ-032 SHALL, on ui_clk_sync_rst=1 at a clock edge, set last_gnt=1 (so requester 0 wins the first tie), empty the FIFO, and clear wr_cnt, rd_cnt and err_orphan.
REQ-033 SHALL hold gnt, wr_en, rd_en and rsp_valid at 0 while reset is asserted.
REQ-034 SHALL discard outstanding read tags on reset asserted mid-operation; read data returned afterwards sets err_orphan.

Structure
REQ-035 SHALL define in package ddr_arb_pkg: NUM_REQ=2, default ADDR_W/DATA_W, the req_id_t typedef, and a cmd_t struct (we, addr, wdata).
REQ-036 SHALL implement the tag FIFO as sub-module ddr_arb_tag_fifo (RD_DEPTH x req_id_t, with full, empty and push/pop ports).

Verification
REQ-037 SHALL cover: both requesters request writes, busy=0, for 4 cycles -> gnt sequence 01,10,01,10; wr_cnt=4.
REQ-038 SHALL cover: requester 0 reads address 0x10, then requester 1 reads address 0x20, with data returned A then B -> rsp_valid[0] with A, then rsp_valid[1] with B.
REQ-039 SHALL cover: 8 reads issued with no return -> 9th read not granted while a write from the other requester is still granted.
REQ-040 SHALL cover: rd_busy=1 with req 0 reading and req 1 writing -> gnt=10 each cycle; last_gnt rotates only on grant.
REQ-041 SHALL cover: rd_data_valid pulse after reset with no outstanding reads -> err_orphan=1, rsp_valid=00.
REQ-042 SHALL cover: reset asserted with 3 reads outstanding -> counters 0, FIFO empty, the next grant goes to requester 0.
